// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: synchronizes the raw pins, checks start/stop/odd parity,
// and queues good scan codes in a FIFO with a valid/ready read port.
module ps2_scan_rx #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overflow,
    output logic       frame_err
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state_q, state_d;
    logic [2:0]    s_q, s_d;
    logic [1:0]    d_q, d_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [10:0]   sr_q, sr_d;
    logic [TW-1:0] to_q, to_d;
    logic          frame_err_q, frame_err_d;
    logic          overflow_q, overflow_d;
    logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];

    logic          fe, good, push_req, push, pop, full;
    logic [10:0]   frame;

    assign fe    = s_q[2] & ~s_q[1];
    // Frame as it will look once the current sample is shifted in (bit 0 = start).
    assign frame = {d_q[1], sr_q[10:1]};
    assign good  = ~frame[0] & frame[10] & (^frame[9:1]);

    assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign out_valid = (wptr_q != rptr_q);
    assign out_data  = mem_q[rptr_q[AW-1:0]];
    assign pop       = out_valid & out_ready;
    assign push      = push_req & (~full | pop);
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

    always_comb begin
        s_d         = {s_q[1:0], ps2_clk};
        d_d         = {d_q[0], ps2_data};
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        sr_d        = sr_q;
        to_d        = to_q;
        frame_err_d = 1'b0;
        push_req    = 1'b0;
        case (state_q)
            IDLE: begin
                to_d = '0;
                if (fe) begin
                    state_d  = SHIFT;
                    bitcnt_d = 4'd1;
                    sr_d     = frame;
                end
            end
            SHIFT: begin
                if (fe) begin
                    sr_d = frame;
                    to_d = '0;
                    if (bitcnt_q == 4'd10) begin
                        state_d  = IDLE;
                        bitcnt_d = '0;
                        if (good) push_req = 1'b1;
                        else      frame_err_d = 1'b1;
                    end else begin
                        bitcnt_d = bitcnt_q + 4'd1;
                    end
                end else if (to_q == TW'(TIMEOUT_CYC)) begin
                    state_d     = IDLE;
                    bitcnt_d    = '0;
                    to_d        = '0;
                    frame_err_d = 1'b1;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_d      = mem_q;
        overflow_d = overflow_q | (push_req & ~push);
        wptr_d     = wptr_q + (AW + 1)'(push);
        rptr_d     = rptr_q + (AW + 1)'(pop);
        if (push) mem_d[wptr_q[AW-1:0]] = frame[8:1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            s_q         <= '1;
            d_q         <= '1;
            bitcnt_q    <= '0;
            sr_q        <= '0;
            to_q        <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            mem_q       <= '{default: '0};
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            d_q         <= d_d;
            bitcnt_q    <= bitcnt_d;
            sr_q        <= sr_d;
            to_q        <= to_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            mem_q       <= mem_d;
        end
    end
endmodule

// File: tb/tb_ps2_scan_rx.sv
// Directed bench for ps2_scan_rx: bit-banged PS/2 frames with hand-computed expectations.
module tb_ps2_scan_rx;
    localparam int unsigned TO = 300;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       overflow;
    logic       frame_err;

    int errors = 0;
    int checks = 0;
    int err_cyc = 0;
    int err_base;

    ps2_scan_rx #(.FIFO_DEPTH(8), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .overflow(overflow), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Cycles with frame_err high, so a single pulse adds exactly 1.
    always @(negedge clk) if (frame_err === 1'b1) err_cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Frame bits in arrival order: start, data LSB first, parity, stop.
    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad_par);
        return {1'b1, (~^d) ^ bad_par, d, 1'b0};
    endfunction

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        cyc(4);
        ps2_clk = 1'b0;
        cyc(8);
        ps2_clk = 1'b1;
        cyc(4);
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) ps2_bit(f[i]);
    endtask

    task automatic pop_one;
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [10:0] f;

        cyc(2);
        rst = 1'b0;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);

        // Good 0x1C, with latency check on the final falling edge.
        err_base = err_cyc;
        f = mk_frame(8'h1C, 1'b0);
        send_bits(f, 10);
        ps2_data = f[10];
        cyc(4);
        ps2_clk = 1'b0;
        cyc(4);
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_data", 32'(out_data), 32'h1C);
        cyc(4);
        ps2_clk = 1'b1;
        cyc(10);
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'h1C);
        check("good_no_err", 32'(err_cyc - err_base), 32'd0);
        pop_one();
        check("pop_empty", 32'(out_valid), 32'd0);

        // Parity error, then good 0xF0.
        err_base = err_cyc;
        send_bits(mk_frame(8'h1C, 1'b1), 11);
        cyc(4);
        check("par_err_pulse", 32'(err_cyc - err_base), 32'd1);
        check("par_no_push", 32'(out_valid), 32'd0);
        send_bits(mk_frame(8'hF0, 1'b0), 11);
        check("f0_valid", 32'(out_valid), 32'd1);
        check("f0_data", 32'(out_data), 32'hF0);
        check("f0_no_err", 32'(err_cyc - err_base), 32'd1);
        pop_one();

        // Overflow: nine frames with no reads.
        for (int i = 1; i <= 8; i++) send_bits(mk_frame(8'(i), 1'b0), 11);
        check("full_no_ovf", 32'(overflow), 32'd0);
        send_bits(mk_frame(8'h09, 1'b0), 11);
        check("ovf_set", 32'(overflow), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            check("ovf_drain_valid", 32'(out_valid), 32'd1);
            check("ovf_drain_data", 32'(out_data), 32'(i));
            pop_one();
        end
        check("ovf_drained", 32'(out_valid), 32'd0);
        cyc(20);
        check("ovf_sticky", 32'(overflow), 32'd1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("ovf_rst_clear", 32'(overflow), 32'd0);

        // Timeout after a 5-bit partial frame.
        err_base = err_cyc;
        send_bits(mk_frame(8'hAA, 1'b0), 5);
        cyc(TO + 2);
        check("to_err_pulse", 32'(err_cyc - err_base), 32'd1);
        check("to_no_push", 32'(out_valid), 32'd0);
        send_bits(mk_frame(8'h5A, 1'b0), 11);
        check("to_next_valid", 32'(out_valid), 32'd1);
        check("to_next_data", 32'(out_data), 32'h5A);
        check("to_next_no_err", 32'(err_cyc - err_base), 32'd1);
        pop_one();

        // Full FIFO, pop coincides with the push of the 9th frame.
        for (int i = 1; i <= 8; i++) send_bits(mk_frame(8'(i), 1'b0), 11);
        f = mk_frame(8'h09, 1'b0);
        send_bits(f, 10);
        ps2_data = f[10];
        cyc(4);
        ps2_clk = 1'b0;
        cyc(2);
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
        cyc(5);
        ps2_clk = 1'b1;
        cyc(4);
        check("simul_no_ovf", 32'(overflow), 32'd0);
        for (int i = 2; i <= 9; i++) begin
            check("simul_drain_valid", 32'(out_valid), 32'd1);
            check("simul_drain_data", 32'(out_data), 32'(i));
            pop_one();
        end
        check("simul_drained", 32'(out_valid), 32'd0);

        // Reset mid-frame with three codes buffered.
        send_bits(mk_frame(8'h11, 1'b0), 11);
        send_bits(mk_frame(8'h22, 1'b0), 11);
        send_bits(mk_frame(8'h33, 1'b0), 11);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        send_bits(mk_frame(8'h77, 1'b0), 6);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        err_base = err_cyc;
        send_bits(mk_frame(8'h29, 1'b0), 11);
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_data", 32'(out_data), 32'h29);
        check("post_rst_no_err", 32'(err_cyc - err_base), 32'd0);
        pop_one();
        check("post_rst_single", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ps2_scan_rx.md
# ps2_scan_rx

Receives PS/2 keyboard frames on the raw `ps2_clk`/`ps2_data` pins and checks each frame's start bit, stop bit and odd parity. Valid scan codes are buffered in a small FIFO. The block sits directly upstream of the scan-code decode stage, a key-indexed lookup mux that maps scan code to ASCII or a display pattern. It presents one 8-bit scan code at a time with a valid/ready handshake, so the decoder's key input is stable while it is consumed.

## Interface
- `FIFO_DEPTH`, default 8: number of buffered scan codes; power of 2, at least 2.
- `TIMEOUT_CYC`, default 50000: system-clock cycles without a `ps2_clk` falling edge, mid-frame, before the partial frame is discarded.
- `clk`  in  1: system clock. One clock domain only.
- `rst`  in  1: reset, synchronous, active-high.
- `ps2_clk`  in  1: raw PS/2 clock pin, asynchronous to `clk`.
- `ps2_data`  in  1: raw PS/2 data pin, asynchronous to `clk`.
- `out_data`  out  8: scan code at the FIFO head. Drives the decoder key.
- `out_valid`  out  1: FIFO not empty.
- `out_ready`  in  1: consumer accepts the head entry.
- `overflow`  out  1: sticky. Set when a good frame is dropped because the FIFO is full.
- `frame_err`  out  1: one-cycle pulse on a start, stop or parity error, or on a timeout.

## Operation
- Synchronizer:
  - `ps2_clk` passes through a 3-flop chain `s0→s1→s2`.
  - `ps2_data` passes through a 2-flop chain `d0→d1`.
  - Falling edge `fe` = `s2 & ~s1`. The data sample is taken from `d1` in the `fe` cycle.
- Receiver FSM, states IDLE and SHIFT:
  - IDLE: on `fe`, go to SHIFT with `bitcnt=1` and shift the sampled bit in as the start bit.
  - SHIFT: on each `fe`, shift the sample into an 11-bit register, LSB first, and increment `bitcnt`.
  - When the 11th bit is captured (`bitcnt==10` at the `fe`), evaluate the frame and return to IDLE.
- Frame check (bits numbered in arrival order 0..10):
  - Start bit 0 must be 0.
  - Stop bit 10 must be 1.
  - The XOR of data bits 1..8 and parity bit 9 must be 1 (odd parity).
  - Data byte = bits 8..1, with bit 1 as LSB.
- Good frame:
  - Push the data byte if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise drop it and set `overflow`.
  - `frame_err` stays low.
- Bad frame: nothing is pushed, and `frame_err` pulses for exactly one cycle.
- Timeout:
  - A counter runs only in SHIFT, and clears on every `fe`.
  - When it reaches `TIMEOUT_CYC`, go to IDLE, clear `bitcnt`, and pulse `frame_err`.
  - The partial frame is discarded.
- FIFO:
  - Circular buffer with pointers one bit wider than `log2(FIFO_DEPTH)`.
  - Empty when the pointers are equal. Full when the MSBs differ and the remaining bits are equal.
  - `out_data` = `mem[rptr]`, driven combinationally from the registered array.
  - Pop when `out_valid & out_ready`.
  - `out_data` is don't-care while `out_valid=0`; the bench must not check it then.
- Simultaneous events:
  - Push and pop in the same cycle: both take effect and occupancy is unchanged. This holds even when the FIFO is full.
  - Push into an empty FIFO: `out_valid` rises on the next cycle. The data does not bypass the FIFO in the push cycle.
- `overflow` clears only on `rst`.

## Timing
- Reset: `rst` high at a `clk` edge gives the following state.
  - FSM in IDLE; `bitcnt`, shift register and timeout counter at 0.
  - Pointers at 0, so `out_valid=0`.
  - `overflow=0`, `frame_err=0`, `out_data=0` (memory cleared).
  - Synchronizer flops at 1 (bus idle-high).
- Reset mid-frame discards the partial frame and all buffered codes. The next `fe` after reset is treated as a start bit.
- Latency from the 11th `ps2_clk` falling edge to `out_valid` is at most 4 `clk` cycles when the FIFO is empty:
  - 2–3 cycles of synchronization to `fe`.
  - 1 cycle for the push.
- `frame_err` is registered and asserts in the cycle after the evaluating `fe`, or after the timeout.
- Throughput: one pop per cycle. Frames arrive far slower than `clk`: PS/2 runs at 10–16.7 kHz and `clk` is at least 1 MHz.
- Input requirement: `ps2_clk` high and low phases must each be at least 4 `clk` cycles. Narrower glitches may be missed and are not required to be filtered.

## Test plan
- Send valid frame 0x1C (start 0, data LSB first, parity 0, stop 1), then hold `out_ready=0`:
  - `out_valid=1` and `out_data=0x1C` within 4 cycles of the last edge, held stable.
  - Raise `out_ready` for one cycle → `out_valid=0`.
- Send 0x1C with parity bit 1:
  - One-cycle `frame_err`.
  - `out_valid` stays 0.
  - A following good 0xF0 frame is received as 0xF0.
- With `out_ready=0`, send 9 good frames 0x01..0x09:
  - `overflow=1` after the 9th frame.
  - Drain → 0x01..0x08 in order; 0x09 is absent.
  - `overflow` stays 1 until `rst`.
- Send 5 bits, idle `TIMEOUT_CYC+2` cycles, then send 0x5A:
  - One `frame_err` pulse at the timeout.
  - Output 0x5A.
- FIFO full with 8 entries; hold `out_ready=1` while the 9th good frame is pushed:
  - No overflow.
  - Drain order is 0x02..0x09.
- Assert `rst` for 1 cycle after 6 bits of a frame, with 3 codes buffered:
  - `out_valid=0` and `overflow=0`.
  - The next full frame 0x29 is received correctly.
